// File: rtl/servo_decoder_if.sv
// Signal bundle between a servo PWM line and its decoder.
// The slave modport is the decoder side; the master modport drives the line and reads results.
interface servo_decoder_if;
    logic       servo_in;
    logic [9:0] angle;
    logic       angle_valid;
    logic       range_err;
    logic       signal_ok;

    modport master (
        output servo_in,
        input  angle,
        input  angle_valid,
        input  range_err,
        input  signal_ok
    );

    modport slave (
        input  servo_in,
        output angle,
        output angle_valid,
        output range_err,
        output signal_ok
    );
endinterface

// File: rtl/servo_decoder.sv
// Hobby-servo PWM receiver: measures the high time in microseconds and converts it to a
// 0..180 degree angle incrementally while the pulse is still high.
module servo_decoder #(
    parameter int unsigned TICKS_PER_US = 48,
    parameter int unsigned MIN_US       = 500,
    parameter int unsigned MAX_US       = 2500,
    parameter int unsigned MIN_PULSE_US = 100,
    parameter int unsigned MAX_PULSE_US = 3000,
    parameter int unsigned TIMEOUT_US   = 25000
) (
    input  logic            clk,
    input  logic            rst,
    servo_decoder_if.slave  bus
);

    localparam int unsigned PW = (TICKS_PER_US > 2) ? $clog2(TICKS_PER_US) : 1;

    localparam logic [PW-1:0] PrescMax = PW'(TICKS_PER_US - 1);
    localparam logic [11:0]   MinUs    = 12'(MIN_US);
    localparam logic [11:0]   MaxUs    = 12'(MAX_US);
    localparam logic [11:0]   SpanUs   = 12'(MAX_US - MIN_US);
    localparam logic [11:0]   MinPulse = 12'(MIN_PULSE_US);
    localparam logic [11:0]   MaxPulse = 12'(MAX_PULSE_US);
    localparam logic [14:0]   GapMax   = 15'(TIMEOUT_US);
    localparam logic [7:0]    DegMax   = 8'd180;

    typedef enum logic [1:0] {StWaitLow, StWaitRise, StHigh, StDone} state_e;

    state_e        r_state, w_state_nxt;
    logic [2:0]    r_sync;
    logic [PW-1:0] r_presc;
    logic [14:0]   r_gap;
    logic [11:0]   r_width, w_width_nxt;
    logic [11:0]   r_acc, w_acc_nxt, w_acc_sum;
    logic [7:0]    r_deg, w_deg_nxt;
    logic [9:0]    r_angle;
    logic          r_valid, r_range_err, r_signal_ok;
    logic          w_rise, w_fall, w_tick, w_timeout, w_stuck, w_load;

    assign w_rise    = r_sync[1] & ~r_sync[2];
    assign w_fall    = ~r_sync[1] & r_sync[2];
    assign w_tick    = (r_presc == PrescMax);
    assign w_timeout = (r_gap == GapMax);
    assign w_acc_sum = r_acc + 12'd180;

    // Synchronizer resets high so a line already high at reset is never seen as a rising edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync  <= 3'b111;
            r_presc <= '0;
            r_gap   <= '0;
        end else begin
            r_sync <= {r_sync[1:0], bus.servo_in};
            if (w_rise || w_tick) r_presc <= '0;
            else                  r_presc <= r_presc + 1'b1;
            if (w_rise)                      r_gap <= '0;
            else if (w_tick && !w_timeout)   r_gap <= r_gap + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= StWaitLow;
            r_width <= '0;
            r_acc   <= '0;
            r_deg   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_width <= w_width_nxt;
            r_acc   <= w_acc_nxt;
            r_deg   <= w_deg_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_width_nxt = r_width;
        w_acc_nxt   = r_acc;
        w_deg_nxt   = r_deg;
        w_stuck     = 1'b0;
        w_load      = 1'b0;
        unique case (r_state)
            StWaitLow: begin
                if (!r_sync[1]) w_state_nxt = StWaitRise;
            end
            StWaitRise: begin
                if (w_rise) begin
                    w_width_nxt = '0;
                    w_acc_nxt   = '0;
                    w_deg_nxt   = '0;
                    w_state_nxt = StHigh;
                end
            end
            StHigh: begin
                // A tick coinciding with the falling edge is counted before the edge is acted on.
                if (w_tick) begin
                    w_width_nxt = r_width + 1'b1;
                    if (r_width >= MinUs) begin
                        if (w_acc_sum >= SpanUs) begin
                            w_acc_nxt = w_acc_sum - SpanUs;
                            if (r_deg != DegMax) w_deg_nxt = r_deg + 1'b1;
                        end else begin
                            w_acc_nxt = w_acc_sum;
                        end
                    end
                    w_stuck = (w_width_nxt == MaxPulse);
                end
                if (w_stuck) begin
                    w_state_nxt = StWaitLow;
                end else if (w_fall) begin
                    w_state_nxt = StDone;
                    w_load      = (w_width_nxt >= MinPulse);
                end
            end
            StDone: begin
                w_state_nxt = StWaitRise;
            end
            default: w_state_nxt = StWaitLow;
        endcase
    end

    // Results are registered on the falling-edge cycle so they appear while the FSM is in StDone.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_angle     <= '0;
            r_valid     <= 1'b0;
            r_range_err <= 1'b0;
            r_signal_ok <= 1'b0;
        end else begin
            r_valid <= w_load;
            if (w_load) begin
                r_angle     <= {2'b00, w_deg_nxt};
                r_range_err <= (w_width_nxt < MinUs) || (w_width_nxt > MaxUs);
                r_signal_ok <= 1'b1;
            end else if (w_stuck || w_timeout) begin
                r_signal_ok <= 1'b0;
            end
        end
    end

    assign bus.angle       = r_angle;
    assign bus.angle_valid = r_valid;
    assign bus.range_err   = r_range_err;
    assign bus.signal_ok   = r_signal_ok;

endmodule

// File: tb/tb_servo_decoder.sv
// Directed bench for servo_decoder: pulse widths, range limits, glitch, timeout, stuck line, reset.
// Uses 2 clocks per microsecond and a shortened timeout to keep the run short.
module tb_servo_decoder;

    localparam int unsigned T       = 2;
    localparam int unsigned TIMEOUT = 3500;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vectors     = 0;
    int   miscompares = 0;
    int   strobes     = 0;
    int   n0;

    servo_decoder_if bus ();

    servo_decoder #(
        .TICKS_PER_US (T),
        .MIN_US       (500),
        .MAX_US       (2500),
        .MIN_PULSE_US (100),
        .MAX_PULSE_US (3000),
        .TIMEOUT_US   (TIMEOUT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.angle_valid === 1'b1) strobes++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wait_us(input int unsigned us);
        repeat (us * T) @(negedge clk);
    endtask

    task automatic send(input int unsigned width_us, input int unsigned low_us);
        bus.servo_in = 1'b1;
        wait_us(width_us);
        bus.servo_in = 1'b0;
        wait_us(low_us);
    endtask

    task automatic pulse_chk(input string tag, input int unsigned width_us,
                             input int unsigned exp_angle, input logic exp_rerr);
        n0 = strobes;
        send(width_us, 300);
        chk({tag, " strobes"}, 32'(strobes - n0), 32'd1);
        chk({tag, " angle"}, 32'(bus.angle), 32'(exp_angle));
        chk({tag, " range_err"}, 32'(bus.range_err), 32'(exp_rerr));
        chk({tag, " signal_ok"}, 32'(bus.signal_ok), 32'd1);
    endtask

    int unsigned widths [5] = '{500, 511, 512, 2000, 2500};
    int unsigned angles [5] = '{0, 0, 1, 135, 180};

    initial begin
        bus.servo_in = 1'b0;
        repeat (4) @(negedge clk);
        chk("reset angle", 32'(bus.angle), 32'd0);
        chk("reset valid", 32'(bus.angle_valid), 32'd0);
        chk("reset range_err", 32'(bus.range_err), 32'd0);
        chk("reset signal_ok", 32'(bus.signal_ok), 32'd0);
        rst = 1'b0;
        wait_us(50);
        chk("idle signal_ok", 32'(bus.signal_ok), 32'd0);

        pulse_chk("1500 first", 1500, 90, 1'b0);
        pulse_chk("1500 second", 1500, 90, 1'b0);

        for (int i = 0; i < 5; i++) begin
            pulse_chk($sformatf("w%0d", widths[i]), widths[i], angles[i], 1'b0);
        end

        pulse_chk("w400", 400, 0, 1'b1);
        pulse_chk("w2700", 2700, 180, 1'b1);

        n0 = strobes;
        send(50, 300);
        chk("glitch strobes", 32'(strobes - n0), 32'd0);
        chk("glitch angle held", 32'(bus.angle), 32'd180);
        chk("glitch range_err held", 32'(bus.range_err), 32'd1);

        // Timeout: measured from the rising edge of the last pulse.
        pulse_chk("pre-timeout", 1500, 90, 1'b0);
        wait_us(TIMEOUT - 1800 - 50);
        chk("timeout not yet", 32'(bus.signal_ok), 32'd1);
        wait_us(100);
        chk("timeout signal_ok", 32'(bus.signal_ok), 32'd0);
        chk("timeout angle held", 32'(bus.angle), 32'd90);
        wait_us(300);
        pulse_chk("after timeout 1000", 1000, 45, 1'b0);

        // Stuck-high line.
        n0 = strobes;
        bus.servo_in = 1'b1;
        wait_us(2950);
        chk("stuck before limit", 32'(bus.signal_ok), 32'd1);
        wait_us(250);
        chk("stuck signal_ok", 32'(bus.signal_ok), 32'd0);
        bus.servo_in = 1'b0;
        wait_us(200);
        chk("stuck strobes", 32'(strobes - n0), 32'd0);
        chk("stuck angle held", 32'(bus.angle), 32'd45);
        pulse_chk("after stuck", 1500, 90, 1'b0);

        // Reset released with the line high: partial pulse must be discarded.
        bus.servo_in = 1'b1;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset2 angle", 32'(bus.angle), 32'd0);
        rst = 1'b0;
        n0 = strobes;
        wait_us(800);
        bus.servo_in = 1'b0;
        wait_us(300);
        chk("partial strobes", 32'(strobes - n0), 32'd0);
        chk("partial signal_ok", 32'(bus.signal_ok), 32'd0);
        pulse_chk("post-partial", 1500, 90, 1'b0);

        // Asynchronous reset mid-pulse.
        n0 = strobes;
        bus.servo_in = 1'b1;
        wait_us(700);
        #1 rst = 1'b1;
        #1;
        chk("midreset angle", 32'(bus.angle), 32'd0);
        chk("midreset valid", 32'(bus.angle_valid), 32'd0);
        chk("midreset range_err", 32'(bus.range_err), 32'd0);
        chk("midreset signal_ok", 32'(bus.signal_ok), 32'd0);
        bus.servo_in = 1'b0;
        wait_us(50);
        chk("midreset strobes", 32'(strobes - n0), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
